// File: rtl/datamemory_pkg.sv
// Shared encodings for the data-memory load/store unit: RISC-V FUNCT3 access codes,
// FSM states and the access-legality check.
package datamemory_pkg;

    localparam logic [2:0] F3_B   = 3'b000;
    localparam logic [2:0] F3_H   = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_D   = 3'b011;
    localparam logic [2:0] F3_BU  = 3'b100;
    localparam logic [2:0] F3_HU  = 3'b101;
    localparam logic [2:0] F3_WU  = 3'b110;
    localparam logic [2:0] F3_ILL = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Misalignment or an encoding that has no meaning for this direction/word width.
    function automatic logic access_fault(logic we, logic [2:0] f3, logic [2:0] alow, logic wide);
        logic mis;
        case (f3)
            F3_B, F3_BU: mis = 1'b0;
            F3_H, F3_HU: mis = alow[0];
            F3_W, F3_WU: mis = |alow[1:0];
            default:     mis = |alow;
        endcase
        return mis || (f3 == F3_ILL) || (we && f3[2]) || (!wide && (f3 == F3_D || f3 == F3_WU));
    endfunction

endpackage

// File: rtl/datamemory_lsu_load_extend.sv
// Picks the addressed byte lanes out of a memory word and sign/zero-extends them to SIZE.
module load_extend
    import datamemory_pkg::*;
#(
    parameter int SIZE = 64
) (
    input  logic [SIZE-1:0]           word,
    input  logic [$clog2(SIZE/8)-1:0] lane,
    input  logic [2:0]                funct3,
    output logic [SIZE-1:0]           data
);

    logic [SIZE-1:0] shifted;
    logic [SIZE-1:0] mask;
    logic            sgn;
    int              w;

    always_comb begin
        shifted = word >> {lane, 3'b000};
        w = SIZE;
        case (funct3)
            F3_B, F3_BU: w = 8;
            F3_H, F3_HU: w = 16;
            F3_W, F3_WU: w = 32;
            default:     w = SIZE;
        endcase
        mask = '1;
        data = shifted;
        sgn  = 1'b0;
        if (w < SIZE) begin
            mask = ~({SIZE{1'b1}} << w);
            // mask ^ (mask >> 1) isolates the top bit of the access
            sgn  = |(shifted & (mask ^ (mask >> 1)));
            data = shifted & mask;
            if (!(funct3 inside {F3_BU, F3_HU, F3_WU}) && sgn)
                data = data | ~mask;
        end
    end

endmodule

// File: rtl/datamemory_lsu.sv
// Fixed-latency single-port data memory with RISC-V byte/half/word/double load-store semantics.
module datamemory_lsu
    import datamemory_pkg::*;
#(
    parameter int SIZE    = 64,
    parameter int N       = 32,
    parameter int LATENCY = 2
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          REQ,
    input  logic                          WE,
    input  logic [2:0]                    FUNCT3,
    input  logic [$clog2(N*SIZE/8)-1:0]   ADDR,
    input  logic [SIZE-1:0]               D_in,
    output logic [SIZE-1:0]               D_out,
    output logic                          BUSY,
    output logic                          DONE,
    output logic                          FAULT
);

    localparam int NB = SIZE / 8;
    localparam int LB = $clog2(NB);
    localparam int AW = $clog2(N * NB);
    localparam int CW = 4;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic            q_we;
    logic [2:0]      q_f3;
    logic [AW-1:0]   q_addr;
    logic [SIZE-1:0] q_din;
    logic            fault_q;

    logic            accept, commit;
    logic            op_we, op_fault;
    logic [2:0]      op_f3;
    logic [AW-1:0]   op_addr;
    logic [SIZE-1:0] op_din;
    logic [LB-1:0]   lane;
    logic [AW-LB-1:0] widx;
    logic [NB-1:0]   bmask, wmask;
    logic [SIZE-1:0] wdata, rword, ld_data;

    reg [SIZE-1:0] MEM [N-1:0];

    assign accept = REQ && (state == IDLE || state == RESP);

    // With single-cycle latency the access completes on its own acceptance edge,
    // so it must use the live request rather than the captured copy.
    assign op_we   = (LATENCY == 1) ? WE     : q_we;
    assign op_f3   = (LATENCY == 1) ? FUNCT3 : q_f3;
    assign op_addr = (LATENCY == 1) ? ADDR   : q_addr;
    assign op_din  = (LATENCY == 1) ? D_in   : q_din;
    assign commit  = (LATENCY == 1) ? accept : (state == WAIT && cnt == '0);

    assign lane     = op_addr[LB-1:0];
    assign widx     = op_addr[AW-1:LB];
    assign op_fault = access_fault(op_we, op_f3, op_addr[2:0], SIZE == 64);

    always_comb begin
        case (op_f3[1:0])
            2'b00:   bmask = NB'(8'h01);
            2'b01:   bmask = NB'(8'h03);
            2'b10:   bmask = NB'(8'h0F);
            default: bmask = NB'(8'hFF);
        endcase
        wmask = bmask << lane;
        wdata = op_din << {lane, 3'b000};
        rword = MEM[widx];
    end

    load_extend #(.SIZE(SIZE)) u_ext (
        .word   (rword),
        .lane   (lane),
        .funct3 (op_f3),
        .data   (ld_data)
    );

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE, RESP: begin
                if (REQ) begin
                    if (LATENCY == 1) begin
                        state_nx = RESP;
                    end else begin
                        state_nx = WAIT;
                        cnt_nx   = CW'(LATENCY - 2);
                    end
                end else begin
                    state_nx = IDLE;
                end
            end
            WAIT: begin
                if (cnt == '0) state_nx = RESP;
                else           cnt_nx   = cnt - 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            cnt     <= '0;
            D_out   <= '0;
            fault_q <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                q_we   <= WE;
                q_f3   <= FUNCT3;
                q_addr <= ADDR;
                q_din  <= D_in;
            end
            if (commit) begin
                fault_q <= op_fault;
                if (op_fault)   D_out <= '0;
                else if (!op_we) D_out <= ld_data;
            end
        end
    end

    // Storage is deliberately outside the reset domain.
    always_ff @(posedge CLK) begin
        if (!RST && commit && op_we && !op_fault) begin
            for (int b = 0; b < NB; b++)
                if (wmask[b]) MEM[widx][b*8 +: 8] <= wdata[b*8 +: 8];
        end
    end

    assign BUSY  = (state == WAIT);
    assign DONE  = (state == RESP);
    assign FAULT = DONE && fault_q;

endmodule

// File: doc/datamemory_lsu.md
DATAMEMORY_LSU -- requirements
Module: datamemory_lsu

Interface
REQ-001 SHALL have parameter SIZE, default 64: word width in bits; legal values 32 or 64.
REQ-002 SHALL have parameter N, default 32: memory depth in words; power of two.
REQ-003 SHALL have parameter LATENCY, default 2: cycles from request acceptance to DONE; legal values 1 to 15.
REQ-004 SHALL have port CLK, input, 1: single clock; all state updates on rising edge.
REQ-005 SHALL have port RST, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port REQ, input, 1: access request, sampled when BUSY=0.
REQ-007 SHALL have port WE, input, 1: 1 = store, 0 = load; qualified by REQ.
REQ-008 SHALL have port FUNCT3, input, 3: access size and sign (RISC-V load/store encoding).
REQ-009 SHALL have port ADDR, input, $clog2(N*SIZE/8): byte address.
REQ-010 SHALL have port D_in, input, SIZE: store data, right-aligned.
REQ-011 SHALL have port D_out, output, SIZE: load result, extended to SIZE.
REQ-012 SHALL have port BUSY, output, 1: access in flight; REQ is ignored while high.
REQ-013 SHALL have port DONE, output, 1: one-cycle completion pulse.
REQ-014 SHALL have port FAULT, output, 1: valid with DONE; misaligned or illegal access.

Function
REQ-015 SHALL use FSM states IDLE, WAIT and RESP.
REQ-016 SHALL accept a request on a rising edge where REQ=1 and state is IDLE or RESP, capturing WE, FUNCT3, ADDR and D_in.
REQ-017 SHALL, on acceptance, enter RESP directly if LATENCY=1; otherwise enter WAIT with the counter loaded to LATENCY-2.
REQ-018 SHALL decrement the counter in WAIT and enter RESP on the edge where it equals 0.
REQ-019 SHALL assert DONE exactly LATENCY cycles after the acceptance edge, for exactly one cycle.
REQ-020 SHALL drive BUSY=1 only in WAIT; BUSY=0 in IDLE and RESP, so back-to-back requests issue every LATENCY cycles.
REQ-021 SHALL return from RESP to IDLE when no new request is accepted in that cycle.
REQ-022 SHALL decode FUNCT3 as: 000 LB/SB, 001 LH/SH, 010 LW/SW, 011 LD/SD, 100 LBU, 101 LHU, 110 LWU; stores use only 000-011.
REQ-023 SHALL flag FAULT when the address is not aligned to the access size.
REQ-024 SHALL flag FAULT for FUNCT3=111, for a store with FUNCT3 of 1xx, and, when SIZE=32, for 011 or 110.
REQ-025 SHALL, on FAULT, leave memory unmodified and drive D_out=0 during RESP.
REQ-026 SHALL address memory little-endian: word index = ADDR / (SIZE/8); byte lane = ADDR mod (SIZE/8).
REQ-027 SHALL, for a store, write the low 8/16/32/64 bits of D_in to the addressed lanes only, preserving the other lanes.
REQ-028 SHALL commit the store on the edge entering RESP.
REQ-029 SHALL, for a load, sample the addressed lanes on the edge entering RESP.
REQ-030 SHALL sign-extend signed loads and zero-extend unsigned loads (LBU, LHU, LWU) to SIZE.
REQ-031 SHALL hold D_out stable from RESP until the next load completes; stores leave D_out unchanged.
REQ-032 SHALL return the new data for a load accepted in the RESP cycle of a store to the same word.
REQ-033 SHALL ignore REQ while BUSY=1, with no queuing and no side effects.

Reset
REQ-034 SHALL, with RST=1 at a rising edge, force state IDLE, counter 0, D_out 0, DONE 0, FAULT 0, BUSY 0.
REQ-035 SHALL abort an in-flight access on reset mid-operation: no memory write, no DONE.
REQ-036 SHALL NOT clear memory contents on reset.
REQ-037 SHALL give RST priority over REQ.

Structure
REQ-038 SHALL place the FUNCT3 encodings and the FSM state encoding in shared package datamemory_pkg.
REQ-039 SHALL implement lane extraction and sign/zero extension in combinational sub-module load_extend (parameter SIZE).
REQ-040 SHALL infer the storage array as reg[SIZE-1:0] MEM[N-1:0], with byte-lane write masking.

Verification
REQ-041 SHALL cover: SIZE=64, LATENCY=2, SD 0x8877665544332211 @0x80, then LD @0x80 -> DONE 2 cycles after each accept, D_out=0x8877665544332211.
REQ-042 SHALL cover: SB 0xF0 @0x83, then LB @0x83 -> D_out=0xFFFFFFFFFFFFFFF0; LBU @0x83 -> 0xF0; LD @0x80 -> 0x88776655F0332211.
REQ-043 SHALL cover: LW @0x82 -> FAULT=1 with DONE, D_out=0; SH @0x81 -> FAULT=1, word 16 unchanged.
REQ-044 SHALL cover: REQ held high for 6 cycles at LATENCY=3 -> exactly 2 accepts, DONE at cycles 3 and 6, REQ during BUSY ignored.
REQ-045 SHALL cover: RST asserted 1 cycle after SD accept -> no DONE, memory word unchanged, all outputs 0 next cycle.
REQ-046 SHALL cover: LATENCY=1, SW 0x12345678 @0x10 immediately followed by LW @0x10 in its RESP cycle -> DONE every cycle, D_out=0x12345678.
